multi_channel_edge_filter: RTL and testbench

//  N-channel glitch-filtered edge detector with per-channel edge mode, sticky event flags and a

---
 rtl/multi_channel_edge_filter.sv | 102 ++++++++++
 tb/tb_multi_channel_edge_filter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_edge_filter.sv
// N-channel debounced edge detector with per-channel edge mode, sticky flags and maskable irq.
// Define EDGE_FILTER_SYNC_EN to add a 2-flop synchroniser ahead of each channel's filter.
module multi_channel_edge_filter #(
  parameter int CHANNELS   = 4,
  parameter int FILTER_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  input  logic [CHANNELS-1:0]   irq_mask,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   flag,
  output logic [CHANNELS-1:0]   overrun,
  output logic                  irq
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CHANNELS-1:0] samp;

`ifdef EDGE_FILTER_SYNC_EN
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = in;
`endif

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] flag_q, flag_d;
  logic [CHANNELS-1:0] ovr_q, ovr_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = '0;
    flag_d  = flag_q;
    ovr_d   = ovr_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (samp[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = samp[i];
          // bit 0 enables rising edges, bit 1 falling edges
          pulse_d[i] = samp[i] ? mode[2*i] : mode[2*i+1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      // a new event beats a simultaneous clear and leaves overrun as it was
      if (pulse_q[i] && clear[i]) begin
        flag_d[i] = 1'b1;
      end else if (pulse_q[i]) begin
        ovr_d[i]  = ovr_q[i] | flag_q[i];
        flag_d[i] = 1'b1;
      end else if (clear[i]) begin
        flag_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      ovr_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      ovr_q   <= ovr_d;
    end
  end

  assign level   = level_q;
  assign pulse   = pulse_q;
  assign flag    = flag_q;
  assign overrun = ovr_q;
  assign irq     = |(flag_q & irq_mask);

endmodule

// File: tb/tb_multi_channel_edge_filter.sv
// Self-checking bench for multi_channel_edge_filter: directed scenarios plus randomized traffic
// against a run-length reference model. Honours EDGE_FILTER_SYNC_EN for the extra latency.
module tb_multi_channel_edge_filter;

  localparam int CH = 4;
  localparam int FL = 4;
`ifdef EDGE_FILTER_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int LAT = FL + SL;
  localparam int VW  = 4 * CH + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [CH-1:0]   in_r = '0;
  logic [2*CH-1:0] mode_r = '0;
  logic [CH-1:0]   clear_r = '0;
  logic [CH-1:0]   mask_r = '0;
  logic [CH-1:0]   level, pulse, flag, overrun;
  logic            irq;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: accepted level, length of the current run of differing samples, sticky bits
  logic [CH-1:0] m_level, m_pulse, m_flag, m_ovr, m_s1, m_s2;
  int            m_run [CH];

  multi_channel_edge_filter #(.CHANNELS(CH), .FILTER_LEN(FL)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in_r),
    .mode     (mode_r),
    .clear    (clear_r),
    .irq_mask (mask_r),
    .level    (level),
    .pulse    (pulse),
    .flag     (flag),
    .overrun  (overrun),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [CH-1:0] s;
    if (!reset_n) begin
      m_level = '0; m_pulse = '0; m_flag = '0; m_ovr = '0; m_s1 = '0; m_s2 = '0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
      return;
    end
    s = (SL > 0) ? m_s2 : in_r;
    m_s2 = m_s1;
    m_s1 = in_r;
    for (int i = 0; i < CH; i++) begin
      if (m_pulse[i]) begin
        if (!clear_r[i] && m_flag[i]) m_ovr[i] = 1'b1;
        m_flag[i] = 1'b1;
      end else if (clear_r[i]) begin
        m_flag[i] = 1'b0;
        m_ovr[i]  = 1'b0;
      end
      m_pulse[i] = 1'b0;
      if (s[i] == m_level[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == FL) begin
          m_level[i] = s[i];
          m_run[i]   = 0;
          m_pulse[i] = s[i] ? mode_r[2*i] : mode_r[2*i+1];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_level, m_pulse, m_flag, m_ovr, |(m_flag & mask_r)};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; in_r = '0; clear_r = '0; mode_r = '0; mask_r = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [CH-1:0] el, ep;
    reset_n = 1'b0; in_r = '1; mode_r = '1; clear_r = '0; mask_r = '1;
    tick(); tick(); tick();
    n_checks++;
    if ({level, pulse, flag, overrun, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {level, pulse, flag, overrun, irq});
    end
    reset_n = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      el = (k >= LAT) ? '1 : '0;
      ep = (k == LAT) ? '1 : '0;
      n_checks++;
      if ({level, pulse} !== {el, ep}) begin
        n_fail++;
        $display("FAIL reset_release k=%0d: level/pulse got %h/%h expected %h/%h", k, level, pulse, el, ep);
      end
      n_checks++;
      if ({level, pulse, flag, overrun, irq} !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_release_model k=%0d: got %h expected %h", k, {level, pulse, flag, overrun, irq}, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    int npulse = 0;
    do_reset();
    mode_r[1:0] = 2'b01;
    in_r[0] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 3) in_r[0] = 1'b0;
      tick();
      if (pulse[0]) npulse++;
      n_checks++;
      if ({level, pulse, flag, overrun, irq} !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch_model k=%0d: got %h expected %h", k, {level, pulse, flag, overrun, irq}, exp_vec());
      end
    end
    n_checks++;
    if ({level[0], flag[0], npulse} !== {1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL glitch_ch0: level=%b flag=%b pulses=%0d expected 0/0/0", level[0], flag[0], npulse);
    end
  endtask

  task automatic test_both_edges();
    int npulse = 0;
    logic saw_high = 1'b0;
    do_reset();
    mode_r[3:2] = 2'b11;
    for (int k = 0; k < 16; k++) begin
      in_r[1] = (k < 6);
      tick();
      if (pulse[1]) npulse++;
      if (level[1]) saw_high = 1'b1;
      n_checks++;
      if ({level, pulse, flag, overrun, irq} !== exp_vec()) begin
        n_fail++;
        $display("FAIL both_edges_model k=%0d: got %h expected %h", k, {level, pulse, flag, overrun, irq}, exp_vec());
      end
    end
    n_checks++;
    if ({npulse, saw_high, level[1], flag[1], overrun[1]} !== {32'd2, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL both_edges_ch1: pulses=%0d saw_high=%b level=%b flag=%b overrun=%b expected 2/1/0/1/1",
               npulse, saw_high, level[1], flag[1], overrun[1]);
    end
  endtask

  task automatic test_fall_mask();
    int npulse = 0;
    do_reset();
    mask_r[2] = 1'b1;
    mode_r[5:4] = 2'b10;
    in_r[2] = 1'b1;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      if (pulse[2]) npulse++;
    end
    n_checks++;
    if ({level[2], flag[2], npulse} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL fall_mode_rise: level=%b flag=%b pulses=%0d expected 1/0/0", level[2], flag[2], npulse);
    end
    in_r[2] = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      if (pulse[2]) npulse++;
    end
    n_checks++;
    if ({level[2], flag[2], irq, npulse} !== {1'b0, 1'b1, 1'b1, 32'd1}) begin
      n_fail++;
      $display("FAIL fall_mode_fall: level=%b flag=%b irq=%b pulses=%0d expected 0/1/1/1",
               level[2], flag[2], irq, npulse);
    end
    mask_r[2] = 1'b0;
    #1;
    n_checks++;
    if ({irq, flag[2]} !== 2'b01) begin
      n_fail++;
      $display("FAIL mask_off: irq=%b flag=%b expected 0/1", irq, flag[2]);
    end
  endtask

  task automatic test_clear_priority();
    logic got;
    do_reset();
    mode_r[7:6] = 2'b11;
    for (int e = 0; e < 3; e++) begin
      in_r[3] = (e != 1);
      got = 1'b0;
      for (int k = 0; k < LAT + 4 && !got; k++) begin
        tick();
        if (pulse[3]) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL clear_wait_pulse e=%0d: no pulse within %0d cycles", e, LAT + 4);
      end
      if (e < 2) begin
        tick(); tick();
      end
    end
    n_checks++;
    if ({flag[3], overrun[3]} !== 2'b11) begin
      n_fail++;
      $display("FAIL clear_setup: flag/overrun got %b%b expected 11", flag[3], overrun[3]);
    end
    clear_r[3] = 1'b1;
    tick();
    clear_r[3] = 1'b0;
    n_checks++;
    if ({flag[3], overrun[3]} !== 2'b11) begin
      n_fail++;
      $display("FAIL clear_vs_set: flag/overrun got %b%b expected 11", flag[3], overrun[3]);
    end
    tick();
    clear_r[3] = 1'b1;
    tick();
    clear_r[3] = 1'b0;
    n_checks++;
    if ({flag[3], overrun[3], irq} !== 3'b000) begin
      n_fail++;
      $display("FAIL clear_plain: flag/overrun/irq got %b%b%b expected 000", flag[3], overrun[3], irq);
    end
  endtask

  task automatic test_reset_mid_count();
    logic el, ep;
    do_reset();
    mode_r = '1;
    in_r[0] = 1'b1;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({level, pulse} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: level/pulse got %h/%h expected 0/0", level, pulse);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT);
      ep = (k == LAT);
      n_checks++;
      if ({level[0], pulse[0]} !== {el, ep}) begin
        n_fail++;
        $display("FAIL mid_reset_restart k=%0d: level/pulse got %b%b expected %b%b", k, level[0], pulse[0], el, ep);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 4) == 0) in_r[i] = ~in_r[i];
        clear_r[i] = ($urandom_range(0, 9) == 0);
      end
      if (c % 50 == 0) mode_r = $urandom();
      if (c % 30 == 0) mask_r = $urandom();
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
      n_checks++;
      if ({level, pulse, flag, overrun, irq} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c=%0d: got %h expected %h", c, {level, pulse, flag, overrun, irq}, exp_vec());
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_both_edges();
    test_fall_mask();
    test_clear_priority();
    test_reset_mid_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
